diff_accumulator: RTL and testbench

Downstream stage of the 32-bit subtracter. Consumes the 33-bit signed difference stream over a valid/ready handshake and accumulates a burst of differences into a saturating signed sum. At burst end it presents the sum, beat count, negative-result count and a sticky saturation flag on a held output until the consumer takes them. Typical users: checksum/delta-tracking logic fed by the subtracter.

---
 rtl/diff_pkg.sv | 20 ++
 rtl/diff_accumulator_if.sv | 22 ++
 rtl/diff_accumulator_sat_counter.sv | 20 ++
 rtl/diff_accumulator.sv | 52 +++++
 tb/tb_diff_accumulator.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/diff_pkg.sv
// diff_pkg: shared types, widths and saturating-add helper for the difference pipeline
package diff_pkg;
  localparam int DIFF_W = 33;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  typedef struct packed {
    logic               ovf;
    logic signed [64:0] sum;
  } sat_res_t;
  // Adds two sign-extended operands at 65 bits and clamps to a signed w-bit range (w <= 64).
  function automatic sat_res_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [64:0] s, hi, lo;
    sat_res_t r;
    s = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = ~hi;
    r.ovf = (s > hi) || (s < lo);
    r.sum = s > hi ? hi : s < lo ? lo : s;
    return r;
  endfunction
endpackage

// File: rtl/diff_accumulator_if.sv
// diff_accumulator_if: beat input (valid/ready/diff/last) and burst result output (valid/ready/sum/count/neg/sat)
interface diff_accumulator_if #(parameter int ACC_W = 40, parameter int CNT_W = 8);
  import diff_pkg::*;
  logic                    in_valid;
  logic                    in_ready;
  logic [DIFF_W-1:0]       in_diff;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic [CNT_W-1:0]        out_neg;
  logic                    out_sat;
  modport master (
    output in_valid, in_diff, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_neg, out_sat
  );
  modport slave (
    input  in_valid, in_diff, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_neg, out_sat
  );
endinterface

// File: rtl/diff_accumulator_sat_counter.sv
// sat_counter: loadable up-counter that sticks at all-ones
//   clk, rst_n (sync, active-low), load/load_val (load wins over inc), inc, value
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;
  always_comb begin
    value_d = load ? load_val : (inc && !(&value_q)) ? value_q + W'(1) : value_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/diff_accumulator.sv
// diff_accumulator: accumulates a burst of 33-bit signed differences into a saturating sum
//   clk, rst_n (sync, active-low); bus.slave carries the beat input and the held burst result
module diff_accumulator import diff_pkg::*; #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  diff_accumulator_if.slave bus
);
  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    sat_q, sat_d;
  logic                    accept, first, take, neg_beat;
  sat_res_t                add_r;
  logic                    unused_hi;
  assign accept = bus.in_valid && state_q != HOLD;
  assign first = state_q == IDLE;
  assign take = state_q == HOLD && bus.out_ready;
  assign neg_beat = bus.in_diff[DIFF_W-1];
  assign add_r = sat_add(64'(sum_q), 64'($signed(bus.in_diff)), ACC_W);
  // Clamped result already lies in ACC_W bits; the upper bits are only sign copies.
  assign unused_hi = ^add_r.sum[64:ACC_W];
  always_comb begin
    state_d = accept ? (bus.in_last ? HOLD : ACCUM) : take ? IDLE : state_q;
    sum_d = !accept ? sum_q : first ? ACC_W'($signed(bus.in_diff)) : add_r.sum[ACC_W-1:0];
    sat_d = !accept ? sat_q : !first && (sat_q || add_r.ovf);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      sat_q <= sat_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_count (
    .clk(clk), .rst_n(rst_n), .load(accept && first), .load_val(CNT_W'(1)),
    .inc(accept && !first), .value(bus.out_count)
  );
  sat_counter #(.W(CNT_W)) u_neg (
    .clk(clk), .rst_n(rst_n), .load(accept && first), .load_val(CNT_W'(neg_beat)),
    .inc(accept && !first && neg_beat), .value(bus.out_neg)
  );
  assign bus.in_ready = state_q != HOLD;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_sum = sum_q;
  assign bus.out_sat = sat_q;
endmodule

// File: tb/tb_diff_accumulator.sv
// tb_diff_accumulator: directed checks of burst accumulation, saturation, backpressure and reset
module tb_diff_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  diff_accumulator_if #(.ACC_W(34), .CNT_W(4)) bus ();
  diff_accumulator #(.ACC_W(34), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic send(input logic [32:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_diff = d;
    bus.in_last = last;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL send_ready_timeout got=%0b exp=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic take_result(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s_take_valid got=%0b exp=0", name, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_take_ready got=%0b exp=1", name, bus.in_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_diff = 33'h0_00000055;
    bus.in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_sum !== 34'h0) begin failures++; $display("FAIL reset_sum got=%0h exp=0", bus.out_sum); end
    checks++; if (bus.out_count !== 4'h0) begin failures++; $display("FAIL reset_count got=%0h exp=0", bus.out_count); end
    checks++; if (bus.out_neg !== 4'h0) begin failures++; $display("FAIL reset_neg got=%0h exp=0", bus.out_neg); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", bus.out_sat); end
  endtask

  task automatic test_two_beat;
    send(33'h0_00EFFF10, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL two_beat_mid_valid got=%0b exp=0", bus.out_valid); end
    send(33'h1_FF1000F0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL two_beat_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL two_beat_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_sum !== 34'h0) begin failures++; $display("FAIL two_beat_sum got=%0h exp=0", bus.out_sum); end
    checks++; if (bus.out_count !== 4'h2) begin failures++; $display("FAIL two_beat_count got=%0h exp=2", bus.out_count); end
    checks++; if (bus.out_neg !== 4'h1) begin failures++; $display("FAIL two_beat_neg got=%0h exp=1", bus.out_neg); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL two_beat_sat got=%0b exp=0", bus.out_sat); end
    take_result("two_beat");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) send(33'h0_FFFFFFFF, i == 2);
    checks++; if (bus.out_sum !== 34'h1_FFFFFFFF) begin failures++; $display("FAIL sat_pos_sum got=%0h exp=1ffffffff", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%0b exp=1", bus.out_sat); end
    checks++; if (bus.out_count !== 4'h3) begin failures++; $display("FAIL sat_pos_count got=%0h exp=3", bus.out_count); end
    checks++; if (bus.out_neg !== 4'h0) begin failures++; $display("FAIL sat_pos_neg got=%0h exp=0", bus.out_neg); end
    take_result("sat_pos");
    for (int i = 0; i < 3; i++) send(33'h1_00000001, i == 2);
    checks++; if (bus.out_sum !== 34'h2_00000000) begin failures++; $display("FAIL sat_neg_sum got=%0h exp=200000000", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%0b exp=1", bus.out_sat); end
    checks++; if (bus.out_neg !== 4'h3) begin failures++; $display("FAIL sat_neg_neg got=%0h exp=3", bus.out_neg); end
  endtask

  task automatic test_backpressure;
    bus.in_valid = 1'b1;
    bus.in_diff = 33'h0_00000009;
    bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, bus.in_ready); end
      checks++; if (bus.out_sum !== 34'h2_00000000) begin failures++; $display("FAIL bp_sum[%0d] got=%0h exp=200000000", i, bus.out_sum); end
      checks++; if (bus.out_count !== 4'h3) begin failures++; $display("FAIL bp_count[%0d] got=%0h exp=3", i, bus.out_count); end
    end
    take_result("bp");
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    send(33'h0_00000003, 1'b1);
    checks++; if (bus.out_sum !== 34'h3) begin failures++; $display("FAIL bp_next_sum got=%0h exp=3", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL bp_next_sat got=%0b exp=0", bus.out_sat); end
    checks++; if (bus.out_count !== 4'h1) begin failures++; $display("FAIL bp_next_count got=%0h exp=1", bus.out_count); end
    checks++; if (bus.out_neg !== 4'h0) begin failures++; $display("FAIL bp_next_neg got=%0h exp=0", bus.out_neg); end
    take_result("bp_next");
  endtask

  task automatic test_counter_sat;
    for (int i = 0; i < 20; i++) send(33'h1_FFFFFFFF, i == 19);
    checks++; if (bus.out_count !== 4'hF) begin failures++; $display("FAIL cnt_sat_count got=%0h exp=f", bus.out_count); end
    checks++; if (bus.out_neg !== 4'hF) begin failures++; $display("FAIL cnt_sat_neg got=%0h exp=f", bus.out_neg); end
    checks++; if (bus.out_sum !== 34'h3_FFFFFFEC) begin failures++; $display("FAIL cnt_sat_sum got=%0h exp=3ffffffec", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL cnt_sat_flag got=%0b exp=0", bus.out_sat); end
    take_result("cnt_sat");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) send(33'h0_00000005, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_sum !== 34'h0) begin failures++; $display("FAIL rst_mid_sum got=%0h exp=0", bus.out_sum); end
    checks++; if (bus.out_count !== 4'h0) begin failures++; $display("FAIL rst_mid_count got=%0h exp=0", bus.out_count); end
    send(33'h0_00000007, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_next_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 34'h7) begin failures++; $display("FAIL rst_next_sum got=%0h exp=7", bus.out_sum); end
    checks++; if (bus.out_count !== 4'h1) begin failures++; $display("FAIL rst_next_count got=%0h exp=1", bus.out_count); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL rst_next_sat got=%0b exp=0", bus.out_sat); end
    take_result("rst_next");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_diff = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_two_beat();
    test_saturation();
    test_backpressure();
    test_counter_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
